multicycle_step_sequencer: RTL and testbench



---
 rtl/multicycle_step_sequencer_if.sv | 43 ++++
 rtl/multicycle_step_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_step_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_step_sequencer_if.sv
// Handshake bundle between the multicycle step sequencer and the IR/decoder side.
// SEQ_INSTR_COUNT_EN adds the retired_count output.
interface multicycle_step_sequencer_if #(
    parameter int OPCODE_W  = 5,
    parameter int STEP_W    = 4,
    parameter int MAX_STEPS = 8
);
    logic                 stop;
    logic                 resume;
    logic [OPCODE_W-1:0]  ir_opcode;
    logic                 stall;
    logic                 early_done;
    logic                 run;
    logic                 clear;
    logic [MAX_STEPS-1:0] step;
    logic [STEP_W-1:0]    step_idx;
    logic [OPCODE_W-1:0]  opcode;
    logic                 fetch;
    logic                 instr_done;
    logic                 illegal;
    logic                 halted;
`ifdef SEQ_INSTR_COUNT_EN
    logic [31:0]          retired_count;
`endif

    // Control unit / testbench side: drives the requests, observes the timing.
    modport master (
        output stop, resume, ir_opcode, stall, early_done,
`ifdef SEQ_INSTR_COUNT_EN
        input  retired_count,
`endif
        input  run, clear, step, step_idx, opcode, fetch, instr_done, illegal, halted
    );

    // Sequencer side.
    modport slave (
        input  stop, resume, ir_opcode, stall, early_done,
`ifdef SEQ_INSTR_COUNT_EN
        output retired_count,
`endif
        output run, clear, step, step_idx, opcode, fetch, instr_done, illegal, halted
    );
endinterface

// File: rtl/multicycle_step_sequencer.sv
// T-step timing generator for a multicycle datapath: common fetch steps, then table-driven execute steps.
// Optional macro SEQ_INSTR_COUNT_EN adds a 32-bit retired-instruction counter.
module multicycle_step_sequencer #(
    parameter int OPCODE_W     = 5,
    parameter int STEP_W       = 4,
    parameter int MAX_STEPS    = 8,
    parameter int FETCH_STEPS  = 3,
    parameter int CLEAR_CYCLES = 2,
    parameter int HALT_OP      = 27,
    // Entry i (bits [i*STEP_W +: STEP_W]) is the total step count of opcode i, listed here from opcode 31 down to 0.
    parameter logic [(2**OPCODE_W)*STEP_W-1:0] LEN_TABLE = {
        4'd0, 4'd0, 4'd0, 4'd0,             // 31..28 unassigned
        4'd4, 4'd4, 4'd4, 4'd4, 4'd4,       // HALT NOP MFLO MFHI OUT
        4'd5, 4'd5, 4'd4, 4'd7,             // IN JAL JR BR
        4'd5, 4'd5, 4'd7, 4'd7,             // NOT NEG DIV MUL
        4'd6, 4'd6, 4'd6,                   // ORI ANDI ADDI
        4'd6, 4'd6, 4'd6, 4'd6, 4'd6,       // OR..ADD
        4'd6, 4'd6, 4'd6, 4'd6,
        4'd7, 4'd6, 4'd8                    // ST LDI LD
    }
) (
    input  logic                      clock,
    input  logic                      reset,
    multicycle_step_sequencer_if.slave bus
);
    localparam int LEN_W = STEP_W + 1;
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [STEP_W-1:0]   FETCH_LAST = STEP_W'(FETCH_STEPS - 1);
    localparam logic [STEP_W-1:0]   FETCH_END  = STEP_W'(FETCH_STEPS);
    localparam logic [LEN_W-1:0]    MAX_LEN    = LEN_W'(MAX_STEPS);
    localparam logic [LEN_W-1:0]    MIN_LEN    = LEN_W'(FETCH_STEPS + 1);
    localparam logic [OPCODE_W-1:0] HALT_CODE  = OPCODE_W'(HALT_OP);
    localparam logic [CLR_W-1:0]    CLR_LAST   = CLR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_EXEC, ST_HALTED} state_t;

    state_t              state;
    logic [CLR_W-1:0]    clr_cnt;
    logic [STEP_W-1:0]   step_idx;
    logic [OPCODE_W-1:0] opcode;
    logic [LEN_W-1:0]    len;
    logic                stop_pending;
    logic                run;
    logic                clear;
    logic                halted;
    logic                illegal;

    logic [STEP_W-1:0]    raw_len;
    logic [LEN_W-1:0]     fetched_len;
    logic                 fetch_last;
    logic                 exec_last;
    logic                 halt_req;
    logic                 fetch;
    logic [MAX_STEPS-1:0] step;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        raw_len     = LEN_TABLE[int'(bus.ir_opcode) * STEP_W +: STEP_W];
        fetched_len = {1'b0, raw_len};
        if (fetched_len > MAX_LEN) begin
            fetched_len = MAX_LEN;
        end
        fetch_last = run && !bus.stall && (step_idx == FETCH_LAST);
        // early_done only terminates execute steps; during fetch it has no effect.
        exec_last  = run && !bus.stall && (step_idx >= FETCH_END) &&
                     (({1'b0, step_idx} == len - LEN_W'(1)) || bus.early_done);
        halt_req   = bus.stop || stop_pending;
        fetch      = run && (step_idx < FETCH_END);
        step       = '0;
        if (run) begin
            step = MAX_STEPS'(1) << step_idx;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees the pre-edge values of the others.
        if (reset) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            step_idx     <= '0;
            opcode       <= '0;
            len          <= '0;
            stop_pending <= 1'b0;
            clear        <= 1'b1;
            run          <= 1'b0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state    <= ST_EXEC;
                        clear    <= 1'b0;
                        run      <= 1'b1;
                        step_idx <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (bus.stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (!bus.stall) begin
                        if (fetch_last) begin
                            opcode   <= bus.ir_opcode;
                            len      <= fetched_len;
                            step_idx <= step_idx + STEP_W'(1);
                            // Too short to hold an execute step: flag it and restart fetch.
                            if (fetched_len < MIN_LEN) begin
                                illegal  <= 1'b1;
                                step_idx <= '0;
                                if (halt_req) begin
                                    state        <= ST_HALTED;
                                    run          <= 1'b0;
                                    halted       <= 1'b1;
                                    stop_pending <= 1'b0;
                                end
                            end
                        end else if (exec_last) begin
                            step_idx <= '0;
                            if (opcode == HALT_CODE || halt_req) begin
                                state        <= ST_HALTED;
                                run          <= 1'b0;
                                halted       <= 1'b1;
                                stop_pending <= 1'b0;
                            end
                        end else begin
                            step_idx <= step_idx + STEP_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        state    <= ST_EXEC;
                        run      <= 1'b1;
                        halted   <= 1'b0;
                        step_idx <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [31:0] retired_count;

    // Illegal opcodes never raise instr_done, so they are excluded automatically.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count <= '0;
        end else if (exec_last) begin
            retired_count <= retired_count + 32'd1;
        end
    end

    assign bus.retired_count = retired_count;
`endif

    assign bus.run        = run;
    assign bus.clear      = clear;
    assign bus.step       = step;
    assign bus.step_idx   = step_idx;
    assign bus.opcode     = opcode;
    assign bus.fetch      = fetch;
    assign bus.instr_done = exec_last;
    assign bus.illegal    = illegal;
    assign bus.halted     = halted;
endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// Directed self-checking bench for multicycle_step_sequencer; instr_done/illegal events are
// matched against a scoreboard filled when each opcode is presented.
module tb_multicycle_step_sequencer;
    localparam int OPCODE_W  = 5;
    localparam int STEP_W    = 4;
    localparam int MAX_STEPS = 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    multicycle_step_sequencer_if #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W),
        .MAX_STEPS(MAX_STEPS)
    ) bus ();

    multicycle_step_sequencer dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [OPCODE_W-1:0] op;
        logic [STEP_W-1:0]   idx;
    } ev_t;

    ev_t done_q[$];
    ev_t ill_q[$];
    int  total = 0;
    int  bad   = 0;

    logic                 s_run, s_clear, s_halted, s_fetch, s_done, s_illegal;
    logic [MAX_STEPS-1:0] s_step;
    logic [STEP_W-1:0]    s_idx;
    logic [OPCODE_W-1:0]  s_op;
`ifdef SEQ_INSTR_COUNT_EN
    logic [31:0]          s_retired;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, retire scoreboard events, then move to just after the next rising edge.
    task automatic cyc();
        ev_t e;
        @(negedge clock);
        s_run     = bus.run;
        s_clear   = bus.clear;
        s_halted  = bus.halted;
        s_fetch   = bus.fetch;
        s_done    = bus.instr_done;
        s_illegal = bus.illegal;
        s_step    = bus.step;
        s_idx     = bus.step_idx;
        s_op      = bus.opcode;
`ifdef SEQ_INSTR_COUNT_EN
        s_retired = bus.retired_count;
`endif
        if (s_done !== 1'b0) begin
            check("sb_done_expected", 32'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                e = done_q.pop_front();
                check("sb_done_op", 32'(s_op), 32'(e.op));
                check("sb_done_idx", 32'(s_idx), 32'(e.idx));
            end
        end
        if (s_illegal !== 1'b0) begin
            check("sb_ill_expected", 32'(ill_q.size() > 0), 1);
            if (ill_q.size() > 0) begin
                e = ill_q.pop_front();
                check("sb_ill_op", 32'(s_op), 32'(e.op));
                check("sb_ill_idx", 32'(s_idx), 32'(e.idx));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step_chk(input string tag, input int k, input logic done_exp);
        cyc();
        check({tag, "_run"}, 32'(s_run), 1);
        check({tag, "_idx"}, 32'(s_idx), k);
        check({tag, "_step"}, 32'(s_step), 32'(1) << k);
        check({tag, "_fetch"}, 32'(s_fetch), 32'(k < 3));
        check({tag, "_done"}, 32'(s_done), 32'(done_exp));
    endtask

    // Not running: CLEAR (clr=1) or HALTED (hlt=1).
    task automatic idle_chk(input string tag, input logic clr, input logic hlt);
        check({tag, "_clear"}, 32'(s_clear), 32'(clr));
        check({tag, "_halted"}, 32'(s_halted), 32'(hlt));
        check({tag, "_run"}, 32'(s_run), 0);
        check({tag, "_step"}, 32'(s_step), 0);
        check({tag, "_idx"}, 32'(s_idx), 0);
        check({tag, "_fetch"}, 32'(s_fetch), 0);
        check({tag, "_done"}, 32'(s_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.stop       = 1'b0;
        bus.resume     = 1'b0;
        bus.ir_opcode  = '0;
        bus.stall      = 1'b0;
        bus.early_done = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state and clear phase
        cyc();
        idle_chk("reset", 1'b1, 1'b0);
        check("reset_opcode", 32'(s_op), 0);
        check("reset_illegal", 32'(s_illegal), 0);
`ifdef SEQ_INSTR_COUNT_EN
        check("reset_retired", s_retired, 0);
`endif
        cyc();
        idle_chk("clear2", 1'b1, 1'b0);

        // ADD: six steps, done on step 5
        bus.ir_opcode = 5'd3;
        done_q.push_back('{op: 5'd3, idx: 4'd5});
        for (int k = 0; k < 6; k++) step_chk("add", k, k == 5);
        check("add_opcode", 32'(s_op), 3);
        check("add_clear_low", 32'(s_clear), 0);

        // LD with a three-cycle stall on step 4
        bus.ir_opcode = 5'd0;
        done_q.push_back('{op: 5'd0, idx: 4'd7});
        step_chk("ld", 0, 1'b0);
`ifdef SEQ_INSTR_COUNT_EN
        check("retired_after_add", s_retired, 1);
`endif
        for (int k = 1; k < 4; k++) step_chk("ld", k, 1'b0);
        bus.stall = 1'b1;
        repeat (3) step_chk("ld_stall", 4, 1'b0);
        bus.stall = 1'b0;
        for (int k = 4; k < 8; k++) step_chk("ld", k, k == 7);

        // BR: early_done ignored in fetch, stall beats early_done, then early finish at step 3
        bus.ir_opcode = 5'd19;
        done_q.push_back('{op: 5'd19, idx: 4'd3});
        step_chk("br", 0, 1'b0);
        bus.early_done = 1'b1;
        step_chk("br_early_fetch", 1, 1'b0);
        bus.early_done = 1'b0;
        step_chk("br", 2, 1'b0);
        bus.stall      = 1'b1;
        bus.early_done = 1'b1;
        step_chk("br_stall_early", 3, 1'b0);
        bus.stall = 1'b0;
        step_chk("br_early", 3, 1'b1);
        bus.early_done = 1'b0;

        // Opcode 30 has length 0: illegal, no instr_done, back to step 0
        bus.ir_opcode = 5'd30;
        ill_q.push_back('{op: 5'd30, idx: 4'd0});
        for (int k = 0; k < 3; k++) step_chk("ill", k, 1'b0);

        // NOP with a stop pulse at step 1
        bus.ir_opcode = 5'd26;
        done_q.push_back('{op: 5'd26, idx: 4'd3});
        step_chk("nop", 0, 1'b0);
        check("ill_pulse", 32'(s_illegal), 1);
        check("ill_opcode", 32'(s_op), 30);
`ifdef SEQ_INSTR_COUNT_EN
        check("retired_skip_illegal", s_retired, 3);
`endif
        bus.stop = 1'b1;
        step_chk("nop_stop", 1, 1'b0);
        check("ill_one_cycle", 32'(s_illegal), 0);
        bus.stop = 1'b0;
        step_chk("nop", 2, 1'b0);
        step_chk("nop", 3, 1'b1);

        // HALTED ignores stall/early_done/stop; resume wins over stop
        bus.stall      = 1'b1;
        bus.early_done = 1'b1;
        bus.stop       = 1'b1;
        cyc();
        idle_chk("halt_stop", 1'b0, 1'b1);
        bus.stall      = 1'b0;
        bus.early_done = 1'b0;
        bus.resume     = 1'b1;
        cyc();
        idle_chk("halt_resume_req", 1'b0, 1'b1);
        bus.resume = 1'b0;
        bus.stop   = 1'b0;

        // OUT after resume: runs to completion without halting
        bus.ir_opcode = 5'd23;
        done_q.push_back('{op: 5'd23, idx: 4'd3});
        step_chk("out", 0, 1'b0);
        check("resume_opcode_hold", 32'(s_op), 26);
        check("resume_halted_low", 32'(s_halted), 0);
        for (int k = 1; k < 4; k++) step_chk("out", k, k == 3);

        // HALT opcode stops by itself
        bus.ir_opcode = 5'd27;
        done_q.push_back('{op: 5'd27, idx: 4'd3});
        for (int k = 0; k < 4; k++) step_chk("halt", k, k == 3);
        cyc();
        idle_chk("halt_op", 1'b0, 1'b1);
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;

        // MUL interrupted by reset at step 5
        bus.ir_opcode = 5'd15;
        for (int k = 0; k < 5; k++) step_chk("mul", k, 1'b0);
        reset = 1'b1;
        step_chk("mul", 5, 1'b0);
        reset = 1'b0;
        cyc();
        idle_chk("mul_reset", 1'b1, 1'b0);
        check("mul_reset_opcode", 32'(s_op), 0);
`ifdef SEQ_INSTR_COUNT_EN
        check("mul_reset_retired", s_retired, 0);
`endif
        cyc();
        idle_chk("mul_reset_clear2", 1'b1, 1'b0);

        // ADD with stop on its final step halts right after it
        bus.ir_opcode = 5'd3;
        done_q.push_back('{op: 5'd3, idx: 4'd5});
        for (int k = 0; k < 5; k++) step_chk("add2", k, 1'b0);
        bus.stop = 1'b1;
        step_chk("add2_stop", 5, 1'b1);
        bus.stop = 1'b0;
        cyc();
        idle_chk("add2_halted", 1'b0, 1'b1);
`ifdef SEQ_INSTR_COUNT_EN
        check("retired_hold_halted", s_retired, 1);
`endif
        bus.resume = 1'b1;
        cyc();
        bus.resume = 1'b0;
        step_chk("after_resume", 0, 1'b0);

        check("sb_done_left", done_q.size(), 0);
        check("sb_ill_left", ill_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
